// File: rtl/cache_controller.sv
// Sequencing FSM for the direct-mapped cache: lookup, block fill from memory on a miss,
// single-word response to the CPU, and saturating hit/miss statistics.
module cache_controller #(
    parameter int ADDR_WIDTH  = 15,
    parameter int WORD_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_read,
    input  logic [ADDR_WIDTH-1:0]   cpu_address,
    output logic                    cpu_ready,
    output logic [WORD_WIDTH-1:0]   cpu_data,
    output logic [ADDR_WIDTH-1:0]   cache_address,
    input  logic                    cache_hit,
    input  logic [WORD_WIDTH-1:0]   cache_word,
    output logic                    cache_write,
    output logic [4*WORD_WIDTH-1:0] cache_block,
    output logic                    mem_read,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    input  logic [4*WORD_WIDTH-1:0] mem_block,
    input  logic                    mem_ready,
    output logic [COUNT_WIDTH-1:0]  hit_count,
    output logic [COUNT_WIDTH-1:0]  miss_count
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOOKUP  = 3'd1;
    localparam logic [2:0] MISS    = 3'd2;
    localparam logic [2:0] FILL    = 3'd3;
    localparam logic [2:0] RESPOND = 3'd4;

    logic [2:0]            state;
    logic [WORD_WIDTH-1:0] fill_word;

    // Word 0 of a block sits in the most significant lane.
    always_comb begin
        fill_word = mem_block[4*WORD_WIDTH-1 -: WORD_WIDTH];
        case (cache_address[1:0])
            2'd0: fill_word = mem_block[4*WORD_WIDTH-1 -: WORD_WIDTH];
            2'd1: fill_word = mem_block[3*WORD_WIDTH-1 -: WORD_WIDTH];
            2'd2: fill_word = mem_block[2*WORD_WIDTH-1 -: WORD_WIDTH];
            2'd3: fill_word = mem_block[WORD_WIDTH-1 -: WORD_WIDTH];
            default: fill_word = mem_block[4*WORD_WIDTH-1 -: WORD_WIDTH];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cpu_data      <= '0;
            cache_block   <= '0;
            cache_address <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_read) begin
                        cache_address <= cpu_address;
                        state         <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (cache_hit) begin
                        cpu_data <= cache_word;
                        if (hit_count != '1)
                            hit_count <= hit_count + COUNT_WIDTH'(1);
                        state <= RESPOND;
                    end else begin
                        if (miss_count != '1)
                            miss_count <= miss_count + COUNT_WIDTH'(1);
                        state <= MISS;
                    end
                end
                MISS: begin
                    if (mem_ready) begin
                        cache_block <= mem_block;
                        cpu_data    <= fill_word;
                        state       <= FILL;
                    end
                end
                FILL:    state <= RESPOND;
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are pure state decodes, so reset clears them on the same edge.
    assign cpu_ready   = (state == RESPOND);
    assign cache_write = (state == FILL);
    assign mem_read    = (state == MISS);
    assign mem_address = {cache_address[ADDR_WIDTH-1:2], 2'b00};

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: vector table of full transactions plus
// hand-written sequences for ignored inputs, reset mid-miss and counter saturation.
module tb_cache_controller;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cpu_read = 1'b0;
    logic [14:0]  cpu_address = '0;
    logic         cache_hit = 1'b0;
    logic [31:0]  cache_word = '0;
    logic [127:0] mem_block = '0;
    logic         mem_ready = 1'b0;

    logic         cpu_ready, cache_write, mem_read;
    logic [31:0]  cpu_data;
    logic [14:0]  cache_address, mem_address;
    logic [127:0] cache_block;
    logic [15:0]  hit_count, miss_count;

    // Narrow-counter copy sharing the same stimulus, so saturation is reachable quickly.
    logic         s_cpu_ready, s_cache_write, s_mem_read;
    logic [31:0]  s_cpu_data;
    logic [14:0]  s_cache_address, s_mem_address;
    logic [127:0] s_cache_block;
    logic [2:0]   s_hit_count, s_miss_count;

    cache_controller dut (
        .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_address(cpu_address),
        .cpu_ready(cpu_ready), .cpu_data(cpu_data), .cache_address(cache_address),
        .cache_hit(cache_hit), .cache_word(cache_word), .cache_write(cache_write),
        .cache_block(cache_block), .mem_read(mem_read), .mem_address(mem_address),
        .mem_block(mem_block), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_controller #(.COUNT_WIDTH(3)) u_sat (
        .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_address(cpu_address),
        .cpu_ready(s_cpu_ready), .cpu_data(s_cpu_data), .cache_address(s_cache_address),
        .cache_hit(cache_hit), .cache_word(cache_word), .cache_write(s_cache_write),
        .cache_block(s_cache_block), .mem_read(s_mem_read), .mem_address(s_mem_address),
        .mem_block(mem_block), .mem_ready(mem_ready),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0]  addr;
        logic         hit;
        logic [31:0]  word;
        logic [127:0] blk;
        int           dly;
        logic [31:0]  exp_data;
        int           exp_hits;
        int           exp_miss;
    } vec_t;

    vec_t vecs[8];
    int total = 0;
    int bad = 0;
    int n_ready = 0;
    int n_write = 0;

    always @(negedge clk) begin
        if (cpu_ready === 1'b1) n_ready++;
        if (cache_write === 1'b1) n_write++;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Entered and left at negedge+1 with the DUT in IDLE.
    task automatic run_req(input vec_t v, input bit hold);
        cpu_read    = 1'b1;
        cpu_address = v.addr;
        cache_hit   = v.hit;
        cache_word  = v.word;
        tick;
        if (!hold) cpu_read = 1'b0;
        chk("lookup_addr", cache_address, v.addr);
        chk("lookup_nrdy", cpu_ready, 0);
        tick;
        // Lookup inputs must be ignored from here on.
        cache_hit  = ~v.hit;
        cache_word = 32'hBAD0_BAD0;
        if (v.hit) begin
            chk("hit_rdy", cpu_ready, 1);
            chk("hit_data", cpu_data, v.exp_data);
            chk("hit_nomem", mem_read, 0);
        end else begin
            chk("miss_memrd", mem_read, 1);
            chk("miss_maddr", mem_address, {v.addr[14:2], 2'b00});
            for (int i = 0; i < v.dly; i++) begin
                tick;
                chk("miss_hold", mem_read, 1);
                chk("miss_nwr", cache_write, 0);
            end
            mem_ready = 1'b1;
            mem_block = v.blk;
            tick;
            mem_ready = 1'b0;
            mem_block = '0;
            chk("fill_wr", cache_write, 1);
            chk("fill_blk", cache_block, v.blk);
            chk("fill_nmem", mem_read, 0);
            chk("fill_nrdy", cpu_ready, 0);
            tick;
            chk("miss_rdy", cpu_ready, 1);
            chk("miss_data", cpu_data, v.exp_data);
            chk("resp_nwr", cache_write, 0);
        end
        cpu_read  = 1'b0;
        cache_hit = 1'b0;
        tick;
        chk("idle_nrdy", cpu_ready, 0);
        chk("hit_cnt", hit_count, v.exp_hits);
        chk("miss_cnt", miss_count, v.exp_miss);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   r0, w0;

        vecs[0] = '{15'h0005, 1'b0, 32'h0,
                    {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004},
                    3, 32'hBBBB_0002, 0, 1};
        vecs[1] = '{15'h7FFF, 1'b1, 32'hDEAD_BEEF, 128'h0, 0, 32'hDEAD_BEEF, 1, 1};
        vecs[2] = '{15'h1230, 1'b0, 32'h0, {32'd1, 32'd2, 32'd3, 32'd4}, 1, 32'd1, 1, 2};
        vecs[3] = '{15'h1231, 1'b0, 32'h0, {32'd1, 32'd2, 32'd3, 32'd4}, 0, 32'd2, 1, 3};
        vecs[4] = '{15'h1232, 1'b0, 32'h0, {32'd1, 32'd2, 32'd3, 32'd4}, 2, 32'd3, 1, 4};
        vecs[5] = '{15'h1233, 1'b0, 32'h0, {32'd1, 32'd2, 32'd3, 32'd4}, 0, 32'd4, 1, 5};
        vecs[6] = '{15'h0000, 1'b1, 32'h1234_5678, 128'h0, 0, 32'h1234_5678, 2, 5};
        vecs[7] = '{15'h4ABF, 1'b0, 32'h0,
                    {32'h7777_0001, 32'h7777_0002, 32'h7777_0003, 32'h7777_0004},
                    0, 32'h7777_0004, 2, 6};

        // Reset for two edges.
        rst = 1'b1;
        tick;
        tick;
        chk("rst_rdy", cpu_ready, 0);
        chk("rst_wr", cache_write, 0);
        chk("rst_memrd", mem_read, 0);
        chk("rst_data", cpu_data, 0);
        chk("rst_blk", cache_block, 0);
        chk("rst_caddr", cache_address, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_miss", miss_count, 0);
        rst = 1'b0;
        n_ready = 0;
        n_write = 0;

        foreach (vecs[i]) run_req(vecs[i], 1'b0);
        chk("tbl_nready", n_ready, 8);
        chk("tbl_nwrite", n_write, 6);

        // Spurious mem_ready in IDLE, then a miss with cpu_read held throughout.
        r0 = n_ready;
        w0 = n_write;
        mem_ready = 1'b1;
        mem_block = {4{32'hFFFF_EEEE}};
        tick;
        chk("spur_nwr", cache_write, 0);
        tick;
        chk("spur_nmem", mem_read, 0);
        mem_ready = 1'b0;
        mem_block = '0;
        v = '{15'h2222, 1'b0, 32'h0, {32'd11, 32'd22, 32'd33, 32'd44}, 2, 32'd33, 2, 7};
        run_req(v, 1'b1);
        tick;
        tick;
        chk("hold_nready", n_ready - r0, 1);
        chk("hold_nwrite", n_write - w0, 1);
        chk("hold_miss", miss_count, 7);

        // Reset while the miss is waiting on memory.
        cpu_read    = 1'b1;
        cpu_address = 15'h0100;
        cache_hit   = 1'b0;
        tick;
        cpu_read = 1'b0;
        tick;
        chk("mid_memrd", mem_read, 1);
        r0 = n_ready;
        w0 = n_write;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_memrd0", mem_read, 0);
        chk("mid_hits", hit_count, 0);
        chk("mid_miss", miss_count, 0);
        chk("mid_rdy", cpu_ready, 0);
        mem_ready = 1'b1;
        mem_block = {4{32'h5555_AAAA}};
        tick;
        tick;
        tick;
        mem_ready = 1'b0;
        mem_block = '0;
        chk("mid_nready", n_ready - r0, 0);
        chk("mid_nwrite", n_write - w0, 0);
        v = '{15'h0003, 1'b1, 32'h5A5A_5A5A, 128'h0, 0, 32'h5A5A_5A5A, 1, 0};
        run_req(v, 1'b0);

        // Saturation: 3-bit copy must stick at 7 while the 16-bit one keeps counting.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            v = '{15'(i * 4), 1'b1, 32'(i + 100), 128'h0, 0, 32'(i + 100), i + 1, 0};
            run_req(v, 1'b0);
        end
        chk("sat_hit", s_hit_count, 3'd7);
        chk("sat_miss0", s_miss_count, 3'd0);
        for (int i = 0; i < 9; i++) begin
            v = '{15'(i + 16), 1'b0, 32'h0, {32'd5, 32'd6, 32'd7, 32'd8}, 0,
                  32'(5 + i % 4), 9, i + 1};
            run_req(v, 1'b0);
        end
        chk("sat_miss", s_miss_count, 3'd7);
        chk("sat_hit_hold", s_hit_count, 3'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
